mem_arbiter: RTL

- Shares the single external 32-bit SRAM between instruction fetch (IF, read-only) and the MEM stage (LW/LB/SW/SB).
- Sequences multi-cycle SRAM read and write timing.
- Asserts a pipeline-wide stall while any request is outstanding.
- Sits between the IF/MEM stages and the SRAM pins; MEM wins structural conflicts over IF.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared SRAM arbiter: serialises IF fetches and MEM loads/stores onto one async SRAM.
// MEM has priority; every ram_* strobe and ack is registered so the pins never glitch.
module mem_arbiter #(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        stall,
  output logic [19:0] ram_addr,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [3:0]  ram_be_n,
  output logic [31:0] ram_wdata,
  output logic        ram_data_oe,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD, WSETUP, WPULSE, WHOLD, ACK} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_owner_mem;
  logic [19:0] r_addr;
  logic        r_ce_n, r_oe_n, r_we_n, r_data_oe;
  logic [3:0]  r_be_n;
  logic [31:0] r_wdata, r_if_rdata, r_mem_rdata;
  logic        r_if_ack, r_mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner_mem <= 1'b0;
      r_addr      <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_be_n      <= 4'b1111;
      r_data_oe   <= 1'b0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_owner_mem <= 1'b1;
            r_addr      <= mem_addr[21:2];
            r_ce_n      <= 1'b0;
            if (mem_we) begin
              r_wdata   <= mem_wdata;
              r_be_n    <= ~mem_be;
              r_data_oe <= 1'b1;
              r_state   <= WSETUP;
            end else begin
              r_oe_n  <= 1'b0;
              r_be_n  <= 4'b0000;
              r_cnt   <= 8'(READ_CYCLES - 1);
              r_state <= RD;
            end
          end else if (if_req) begin
            r_owner_mem <= 1'b0;
            r_addr      <= if_addr[21:2];
            r_ce_n      <= 1'b0;
            r_oe_n      <= 1'b0;
            r_be_n      <= 4'b0000;
            r_cnt       <= 8'(READ_CYCLES - 1);
            r_state     <= RD;
          end
        end
        RD: begin
          if (r_cnt == 8'd0) begin
            if (r_owner_mem) begin
              r_mem_rdata <= ram_rdata;
              r_mem_ack   <= 1'b1;
            end else begin
              r_if_rdata <= ram_rdata;
              r_if_ack   <= 1'b1;
            end
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_be_n  <= 4'b1111;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        WSETUP: begin
          r_we_n  <= 1'b0;
          r_cnt   <= 8'(WRITE_CYCLES - 1);
          r_state <= WPULSE;
        end
        WPULSE: begin
          if (r_cnt == 8'd0) begin
            r_we_n  <= 1'b1;
            r_state <= WHOLD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        WHOLD: begin
          // Only writes reach WHOLD, and only MEM can write.
          r_ce_n    <= 1'b1;
          r_be_n    <= 4'b1111;
          r_data_oe <= 1'b0;
          r_mem_ack <= 1'b1;
          r_state   <= ACK;
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall       = (if_req & ~if_ack) | (mem_req & ~mem_ack);
  assign ram_addr    = r_addr;
  assign ram_ce_n    = r_ce_n;
  assign ram_oe_n    = r_oe_n;
  assign ram_we_n    = r_we_n;
  assign ram_be_n    = r_be_n;
  assign ram_wdata   = r_wdata;
  assign ram_data_oe = r_data_oe;
  assign if_rdata    = r_if_rdata;
  assign if_ack      = r_if_ack;
  assign mem_rdata   = r_mem_rdata;
  assign mem_ack     = r_mem_ack;

endmodule
